line_write_merger: RTL and testbench
====================================

// Module: line_write_merger
// PURPOSE
//  Write-combining line buffer between the CPU store path and the L1/L2 write side.
//  Holds one line and merges successive byte-masked word stores to that line into it.
//  Tracks a per-byte dirty mask and emits the merged line with its mask through a
//  valid/ready handshake on a line change, an explicit flush, or (optionally) when full.
//  Generalises single-shot word insertion: parametrised widths, sequential accumulation.
// PARAMETERS
//  WORD_W      16   store word width in bits, multiple of 8
//  LINE_W      128  line width in bits, multiple of WORD_W
//  ADDR_W      16   byte address width
//  AUTO_FLUSH  0    1: start flush automatically once all LINE_W/8 bytes are dirty
// PORTS
//  clk          in   1            clock; all state updates on rising edge
//  reset        in   1            synchronous, active-high reset
//  wr_valid     in   1            store request valid
//  wr_ready     out  1            store accepted this cycle when wr_valid && wr_ready
//  wr_addr      in   ADDR_W       store byte address (word-aligned bits used)
//  wr_mask      in   WORD_W/8     byte enables; bit b = byte b of the word
//  wr_data      in   WORD_W       store data
//  flush_req    in   1            level request: flush the held line
//  rd_addr      in   ADDR_W       forwarding lookup address
//  rd_byte_hit  out  WORD_W/8     per-byte: buffer holds a dirty byte for rd_addr
//  rd_data      out  WORD_W       buffered word at rd_addr (bytes not hit read 0)
//  out_valid    out  1            flushed line valid
//  out_ready    in   1            downstream accepts line
//  out_addr     out  ADDR_W       line-aligned address (offset bits 0)
//  out_line     out  LINE_W       merged line
//  out_mask     out  LINE_W/8     dirty-byte mask of out_line
// BEHAVIOUR
//  Layout: word i = line[i*WORD_W +: WORD_W]; line byte k = line[8k +: 8], mask bit k.
//  Offset: addr[$clog2(LINE_W/8)-1 : $clog2(WORD_W/8)]. Tag: addr[ADDR_W-1 : $clog2(LINE_W/8)].
//  States: EMPTY (no line), HOLD (line valid, mask != 0), FLUSH (out_valid high).
//  Reset: state EMPTY, mask 0, tag 0, line 0, out_valid 0, rd_byte_hit 0.
//   wr_ready is combinational and is 1 in EMPTY immediately after reset.
//  Reset during FLUSH: the line is dropped; out_valid is 0 the next cycle.
//  wr_ready = 1 in EMPTY; in HOLD only if tag matches, flush_req=0 and no auto-flush pending;
//   wr_ready = 0 in FLUSH. Combinational from state and inputs.
//  EMPTY + accepted store with mask!=0 -> HOLD. Load tag; write only the enabled bytes;
//   mask = those bytes only. No fill from memory; bytes that are not dirty are don't-care.
//  HOLD + accepted matching store: merge the enabled bytes in one cycle; mask |= bytes.
//   The latest store to a byte wins.
//  Store with mask==0: accepted as a no-op. No allocation, no flush, no state change.
//  HOLD + wr_valid with tag mismatch and mask!=0: go to FLUSH; store stalls (wr_ready=0).
//  HOLD + flush_req: go to FLUSH. flush_req has priority over a simultaneous store.
//   flush_req in EMPTY: no-op.
//  AUTO_FLUSH=1: mask becomes all-ones -> FLUSH on the next cycle.
//  FLUSH: out_valid=1; out_addr, out_line, out_mask come from registers and stay stable
//   until out_valid && out_ready. On that cycle: state EMPTY, mask 0.
//   The stalled store is accepted at the earliest on the following cycle.
//  Forwarding: combinational in HOLD/FLUSH on a tag match. rd_byte_hit = mask bits of
//   the word; rd_data = line word AND expanded hit. Both are 0 in EMPTY.
//  Latency: store to visible in rd_data is 1 cycle; flush_req to out_valid is 1 cycle.
// TESTING (defaults unless stated)
//  1 reset held 2 cycles -> out_valid=0, wr_ready=1, rd_byte_hit=00; repeat with reset mid-FLUSH -> out_valid=0 next cycle
//  2 wr 0x1002/11/0xBEEF then 0x1004/01/0x0012, rd 0x1002 -> BEEF, hit=11; flush_req -> out_addr=0x1000, out_line[31:16]=BEEF, [39:32]=12, out_mask=16'h001C
//  3 hold 0x1000, wr 0x2000/11 -> wr_ready=0, out_valid=1 addr 0x1000; out_ready=0 3 cycles -> outputs stable; after handshake, store accepted, next flush out_mask=16'h0003
//  4 AUTO_FLUSH=1: 8 full stores 0x3000..0x300E -> out_valid 1 cycle after 8th, out_mask=16'hFFFF
//  5 wr 0x1000/10/0xAA00 then 0x1000/10/0x5500, and wr mask=00 to 0x4000 -> byte1=55, mask=16'h0002, no flush triggered
//  6 flush_req and matching wr_valid same cycle -> wr_ready=0, FLUSH entered, store accepted after handshake into fresh line

Source files
------------

// File: rtl/line_write_merger.sv
// Write-combining buffer: merges byte-masked word stores into one held line and
// hands the merged line plus its dirty-byte mask downstream when it has to leave.
module line_write_merger #(
    parameter int WORD_W     = 16,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 16,
    parameter int AUTO_FLUSH = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [WORD_W/8-1:0]   wr_mask,
    input  logic [WORD_W-1:0]     wr_data,
    input  logic                  flush_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [WORD_W/8-1:0]   rd_byte_hit,
    output logic [WORD_W-1:0]     rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_W-1:0]     out_addr,
    output logic [LINE_W-1:0]     out_line,
    output logic [LINE_W/8-1:0]   out_mask,
    output logic [1:0]            state_dbg
);
    localparam int WB      = WORD_W / 8;
    localparam int LB      = LINE_W / 8;
    localparam int OFF_LSB = $clog2(WB);
    localparam int TAG_LSB = $clog2(LB);
    localparam int OFF_W   = TAG_LSB - OFF_LSB;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [TAG_W-1:0]    tag_q;
    logic [LB-1:0]       mask_q;
    logic [LINE_W-1:0]   line_q;

    logic [TAG_W-1:0]    wr_tag;
    logic [OFF_W-1:0]    wr_off;
    logic [TAG_W-1:0]    rd_tag;
    logic [OFF_W-1:0]    rd_off;
    logic                wr_tag_match;
    logic                wr_zero;
    logic                auto_pending;
    logic                do_write;
    logic [LB-1:0]       wr_bits;
    logic [WORD_W-1:0]   rd_word;

    assign wr_tag       = wr_addr[ADDR_W-1:TAG_LSB];
    assign wr_off       = wr_addr[TAG_LSB-1:OFF_LSB];
    assign rd_tag       = rd_addr[ADDR_W-1:TAG_LSB];
    assign rd_off       = rd_addr[TAG_LSB-1:OFF_LSB];
    assign wr_tag_match = (wr_tag == tag_q);
    assign wr_zero      = (wr_mask == '0);
    assign auto_pending = (AUTO_FLUSH != 0) && (&mask_q);
    assign wr_bits      = LB'(wr_mask) << (int'(wr_off) * WB);
    assign do_write     = wr_valid && wr_ready && !wr_zero;

    generate
        if (OFF_LSB > 0) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^{wr_addr[OFF_LSB-1:0], rd_addr[OFF_LSB-1:0]};
        end
    endgenerate

    // Both ports use valid/ready: a transfer happens on a rising edge where both are 1.
    // wr_ready never depends on wr_valid; a zero-mask store is always a no-op, so it is
    // taken even on a tag mismatch rather than forcing a flush.
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_EMPTY: begin
                wr_ready = 1'b1;
                if (wr_valid && !wr_zero) state_next = S_HOLD;
            end
            S_HOLD: begin
                wr_ready = !flush_req && !auto_pending && (wr_zero || wr_tag_match);
                if (flush_req || auto_pending || (wr_valid && !wr_zero && !wr_tag_match))
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_EMPTY;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_EMPTY;
            tag_q  <= '0;
            mask_q <= '0;
            line_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_FLUSH && out_ready) begin
                mask_q <= '0;
            end else if (do_write) begin
                if (state == S_EMPTY) begin
                    tag_q  <= wr_tag;
                    mask_q <= wr_bits;
                end else begin
                    mask_q <= mask_q | wr_bits;
                end
            end
            for (int k = 0; k < LB; k++) begin
                if (do_write && wr_bits[k]) line_q[k*8 +: 8] <= wr_data[(k % WB)*8 +: 8];
            end
        end
    end

    // Store forwarding: only dirty bytes of the held line are visible.
    always_comb begin
        rd_byte_hit = '0;
        rd_data     = '0;
        rd_word     = line_q[int'(rd_off)*WORD_W +: WORD_W];
        if (state != S_EMPTY && rd_tag == tag_q) rd_byte_hit = mask_q[int'(rd_off)*WB +: WB];
        for (int b = 0; b < WB; b++) begin
            rd_data[b*8 +: 8] = rd_byte_hit[b] ? rd_word[b*8 +: 8] : 8'h00;
        end
    end

    assign out_addr  = {tag_q, {TAG_LSB{1'b0}}};
    assign out_line  = line_q;
    assign out_mask  = mask_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_line_write_merger.sv
// Bench for line_write_merger: two instances (AUTO_FLUSH 0 and 1) share stimulus;
// a byte-array line model predicts every output each cycle.
module tb_line_write_merger;
    localparam int CMP_W = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [1:0]  wr_mask;
    logic [15:0] wr_data;
    logic        flush_req;
    logic [15:0] rd_addr;
    logic        out_ready;
    logic        sel;

    logic        wr_ready_a, wr_ready_b, out_valid_a, out_valid_b;
    logic [1:0]  rd_byte_hit_a, rd_byte_hit_b, state_dbg_a, state_dbg_b;
    logic [15:0] rd_data_a, rd_data_b, out_addr_a, out_addr_b, out_mask_a, out_mask_b;
    logic [127:0] out_line_a, out_line_b;

    logic        wr_ready_s, out_valid_s;
    logic [1:0]  rd_byte_hit_s;
    logic [15:0] rd_data_s, out_addr_s, out_mask_s;
    logic [127:0] out_line_s;

    assign wr_ready_s    = sel ? wr_ready_b    : wr_ready_a;
    assign out_valid_s   = sel ? out_valid_b   : out_valid_a;
    assign rd_byte_hit_s = sel ? rd_byte_hit_b : rd_byte_hit_a;
    assign rd_data_s     = sel ? rd_data_b     : rd_data_a;
    assign out_addr_s    = sel ? out_addr_b    : out_addr_a;
    assign out_mask_s    = sel ? out_mask_b    : out_mask_a;
    assign out_line_s    = sel ? out_line_b    : out_line_a;

    line_write_merger #(.WORD_W(16), .LINE_W(128), .ADDR_W(16), .AUTO_FLUSH(0)) dut_a (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_a),
        .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data), .flush_req(flush_req),
        .rd_addr(rd_addr), .rd_byte_hit(rd_byte_hit_a), .rd_data(rd_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_addr(out_addr_a),
        .out_line(out_line_a), .out_mask(out_mask_a), .state_dbg(state_dbg_a)
    );

    line_write_merger #(.WORD_W(16), .LINE_W(128), .ADDR_W(16), .AUTO_FLUSH(1)) dut_b (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data), .flush_req(flush_req),
        .rd_addr(rd_addr), .rd_byte_hit(rd_byte_hit_b), .rd_data(rd_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_addr(out_addr_b),
        .out_line(out_line_b), .out_mask(out_mask_b), .state_dbg(state_dbg_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [CMP_W-1:0] got, input logic [CMP_W-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: one line as 16 bytes with dirty flags
    logic [7:0]        m_byte [16];
    bit                m_dirty[16];
    int                m_tag;
    bit                m_hold, m_flush;
    logic [CMP_W-1:0]  exp_q[$];
    bit                last_fire;

    function automatic void model_clear_line();
        for (int k = 0; k < 16; k++) begin
            m_dirty[k] = 1'b0;
            m_byte[k]  = 8'h00;
        end
    endfunction

    function automatic bit all_dirty();
        for (int k = 0; k < 16; k++) if (!m_dirty[k]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
        int w = (int'(a) % 16) / 2;
        for (int b = 0; b < 2; b++) begin
            if (m[b]) begin
                m_byte[2*w+b]  = d[8*b +: 8];
                m_dirty[2*w+b] = 1'b1;
            end
        end
    endfunction

    function automatic logic [CMP_W-1:0] model_pack();
        logic [15:0]  mk = '0;
        logic [127:0] ln = '0;
        for (int k = 0; k < 16; k++) begin
            if (m_dirty[k]) begin
                mk[k]         = 1'b1;
                ln[8*k +: 8]  = m_byte[k];
            end
        end
        return {16'(m_tag * 16), mk, ln};
    endfunction

    function automatic logic [127:0] expand(input logic [15:0] mk);
        logic [127:0] e = '0;
        for (int k = 0; k < 16; k++) if (mk[k]) e[8*k +: 8] = 8'hFF;
        return e;
    endfunction

    function automatic bit model_ready();
        if (m_flush) return 1'b0;
        if (!m_hold) return 1'b1;
        if (flush_req) return 1'b0;
        if (sel && all_dirty()) return 1'b0;
        return (wr_mask == 2'b00) || (int'(wr_addr) / 16 == m_tag);
    endfunction

    function automatic logic [1:0] model_hit(input logic [15:0] a);
        int w = (int'(a) % 16) / 2;
        if (!(m_hold || m_flush) || int'(a) / 16 != m_tag) return 2'b00;
        return {m_dirty[2*w+1], m_dirty[2*w]};
    endfunction

    function automatic logic [15:0] model_rdata(input logic [15:0] a);
        logic [1:0] h = model_hit(a);
        int w = (int'(a) % 16) / 2;
        return {h[1] ? m_byte[2*w+1] : 8'h00, h[0] ? m_byte[2*w] : 8'h00};
    endfunction

    function automatic void model_update();
        logic [CMP_W-1:0] dropped;
        bit mism;
        if (reset) begin
            m_hold = 0; m_flush = 0; m_tag = 0;
            model_clear_line();
            exp_q.delete();
            return;
        end
        if (m_flush) begin
            if (out_ready) begin
                if (exp_q.size() > 0) dropped = exp_q.pop_front();
                m_flush = 0;
                model_clear_line();
            end
            return;
        end
        if (!m_hold) begin
            if (wr_valid && wr_mask != 2'b00) begin
                m_hold = 1;
                m_tag  = int'(wr_addr) / 16;
                model_write(wr_addr, wr_mask, wr_data);
            end
            return;
        end
        mism = wr_valid && wr_mask != 2'b00 && (int'(wr_addr) / 16 != m_tag);
        if (flush_req || (sel && all_dirty()) || mism) begin
            m_hold  = 0;
            m_flush = 1;
            exp_q.push_back(model_pack());
        end else if (wr_valid && wr_mask != 2'b00) begin
            model_write(wr_addr, wr_mask, wr_data);
        end
    endfunction

    // One cycle: inputs set at negedge, outputs checked shortly after, model advanced at posedge.
    task automatic step();
        bit exp_ready;
        logic [CMP_W-1:0] got_v;
        #1;
        last_fire = 1'b0;
        if (!reset) begin
            exp_ready = model_ready();
            last_fire = wr_valid && exp_ready;
            check("wr_ready", wr_ready_s, exp_ready);
            check("out_valid", out_valid_s, m_flush);
            check("rd_byte_hit", rd_byte_hit_s, model_hit(rd_addr));
            check("rd_data", rd_data_s, model_rdata(rd_addr));
            if (m_flush && exp_q.size() > 0) begin
                got_v = {out_addr_s, out_mask_s, out_line_s & expand(exp_q[0][143:128])};
                check("out_line", got_v, exp_q[0]);
            end
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic idle();
        wr_valid = 0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        flush_req = 0; out_ready = 0; rd_addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic store(input logic [15:0] a, input logic [1:0] m, input logic [15:0] d);
        bit done = 1'b0;
        wr_valid = 1; wr_addr = a; wr_mask = m; wr_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = last_fire;
        end
        check("store_accept", done, 1'b1);
        wr_valid = 0; wr_mask = '0;
    endtask

    task automatic handshake();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    initial begin
        sel = 0;
        reset = 1;
        idle();
        m_hold = 0; m_flush = 0; m_tag = 0; last_fire = 0;
        model_clear_line();
        @(negedge clk);

        // 1: reset state, then reset during FLUSH
        do_reset();
        #1;
        check("t1_out_valid", out_valid_s, 1'b0);
        check("t1_wr_ready", wr_ready_s, 1'b1);
        check("t1_hit", rd_byte_hit_s, 2'b00);
        step();
        store(16'h1000, 2'b11, 16'h1111);
        flush_req = 1; step(); flush_req = 0;
        check("t1_in_flush", out_valid_s, 1'b1);
        reset = 1; step(); reset = 0;
        #1;
        check("t1_reset_flush", out_valid_s, 1'b0);
        step();

        // 2: merge two stores, forward, flush
        store(16'h1002, 2'b11, 16'hBEEF);
        store(16'h1004, 2'b01, 16'h0012);
        rd_addr = 16'h1002;
        #1;
        check("t2_rd_data", rd_data_s, 16'hBEEF);
        check("t2_rd_hit", rd_byte_hit_s, 2'b11);
        flush_req = 1; step(); flush_req = 0;
        check("t2_out_addr", out_addr_s, 16'h1000);
        check("t2_word1", out_line_s[31:16], 16'hBEEF);
        check("t2_byte4", out_line_s[39:32], 8'h12);
        check("t2_out_mask", out_mask_s, 16'h001C);
        handshake();

        // 3: line change stalls the store until the old line leaves
        store(16'h1000, 2'b11, 16'hCAFE);
        wr_valid = 1; wr_addr = 16'h2000; wr_mask = 2'b11; wr_data = 16'h4242;
        #1;
        check("t3_stall", wr_ready_s, 1'b0);
        step();
        check("t3_out_valid", out_valid_s, 1'b1);
        check("t3_out_addr", out_addr_s, 16'h1000);
        for (int i = 0; i < 3; i++) step();
        check("t3_held_addr", out_addr_s, 16'h1000);
        handshake();
        #1;
        check("t3_ready_after", wr_ready_s, 1'b1);
        step();
        wr_valid = 0; wr_mask = '0;
        flush_req = 1; step(); flush_req = 0;
        check("t3_out_mask", out_mask_s, 16'h0003);
        check("t3_out_addr2", out_addr_s, 16'h2000);
        handshake();

        // 5: latest store wins; zero-mask store is a no-op
        store(16'h1000, 2'b10, 16'hAA00);
        store(16'h1000, 2'b10, 16'h5500);
        store(16'h4000, 2'b00, 16'h1234);
        #1;
        check("t5_no_flush", out_valid_s, 1'b0);
        flush_req = 1; step(); flush_req = 0;
        check("t5_out_mask", out_mask_s, 16'h0002);
        check("t5_byte1", out_line_s[15:8], 8'h55);
        handshake();

        // 6: flush_req beats a matching store; store lands in a fresh line
        store(16'h1000, 2'b01, 16'h0011);
        flush_req = 1;
        wr_valid = 1; wr_addr = 16'h1002; wr_mask = 2'b11; wr_data = 16'h7777;
        #1;
        check("t6_stall", wr_ready_s, 1'b0);
        step();
        flush_req = 0;
        check("t6_out_mask", out_mask_s, 16'h0001);
        handshake();
        store(16'h1002, 2'b11, 16'h7777);
        flush_req = 1; step(); flush_req = 0;
        check("t6_fresh_mask", out_mask_s, 16'h000C);
        check("t6_fresh_word", out_line_s[31:16], 16'h7777);
        handshake();

        // random, AUTO_FLUSH=0
        for (int i = 0; i < 1500; i++) begin
            wr_valid  = ($urandom_range(0, 1) == 1);
            wr_addr   = 16'(($urandom_range(0, 2) + 16'h100) * 16 + $urandom_range(0, 15));
            wr_mask   = 2'($urandom_range(0, 3));
            wr_data   = 16'($urandom);
            flush_req = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rd_addr   = 16'(($urandom_range(0, 2) + 16'h100) * 16 + $urandom_range(0, 15));
            step();
        end
        idle();

        // 4: AUTO_FLUSH=1 instance
        sel = 1;
        do_reset();
        step();
        for (int i = 0; i < 8; i++) store(16'(16'h3000 + 2 * i), 2'b11, 16'($urandom));
        #1;
        check("t4_pending_ready", wr_ready_s, 1'b0);
        step();
        check("t4_out_valid", out_valid_s, 1'b1);
        check("t4_out_mask", out_mask_s, 16'hFFFF);
        check("t4_out_addr", out_addr_s, 16'h3000);
        handshake();

        // random, AUTO_FLUSH=1
        for (int i = 0; i < 1500; i++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_addr   = 16'(($urandom_range(0, 1) + 16'h200) * 16 + $urandom_range(0, 15));
            wr_mask   = 2'($urandom_range(0, 3));
            wr_data   = 16'($urandom);
            flush_req = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rd_addr   = 16'(($urandom_range(0, 1) + 16'h200) * 16 + $urandom_range(0, 15));
            step();
        end
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
